multicycle_ctrl: RTL and testbench

Parametrised multi-cycle controller for the RISC core, the successor to the single-cycle control path. It sequences each instruction through fetch, decode, execute, memory and write-back states. Instruction and data memory are accessed through req/ack handshakes, so wait-stated memories are supported. It owns the PC and drives the register file, the ALU and the data-memory control lines. Illegal encodings and an optional overflow condition halt the core.

---
 rtl/multicycle_ctrl_if.sv | 23 ++
 rtl/multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Instruction- and data-memory req/ack bundle seen by the multi-cycle controller.
// master = controller side, slave = memory side.
interface multicycle_ctrl_if #(
   parameter int ADDR_W = 16
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_data;
   logic              dmem_req;
   logic              dmem_we;
   logic              dmem_ack;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we,
      input  imem_ack, imem_data, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we,
      output imem_ack, imem_data, dmem_ack
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control path: FETCH/DECODE/EXEC/MEM/WB sequencing over req/ack memories.
// Optional macro OVERFLOW_TRAP_EN: add/sub/addi with ALU overflow halt the core in TRAP.
module multicycle_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int REG_AW = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_ctrl_if.master    mem,
   output logic [REG_AW-1:0]    rs_addr,
   output logic [REG_AW-1:0]    rt_addr,
   output logic [REG_AW-1:0]    rd_addr,
   output logic                 reg_we,
   output logic                 wb_sel,
   output logic [3:0]           alu_op,
   output logic                 alu_src,
   output logic [DATA_W-1:0]    imm_ext,
   input  logic                 alu_zero,
   input  logic                 alu_ovf,
   output logic [ADDR_W-1:0]    pc,
   output logic                 halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   state_t            state_reg;
   logic [31:0]       ir_reg;
   logic [ADDR_W-1:0] pc_reg;
   logic              imem_req_reg;
   logic              dmem_req_reg;
   logic              dmem_we_reg;
   logic              reg_we_reg;
   logic              wb_sel_reg;
   logic              alu_src_reg;
   logic [3:0]        alu_op_reg;
   logic              halted_reg;

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic              is_rtype;
   logic              is_addi;
   logic              is_lw;
   logic              is_sw;
   logic              is_beq;
   logic              is_j;
   logic              funct_ok;
   logic              illegal;
   logic              is_arith;
   logic [3:0]        dec_alu_op;
   logic              ovf_trap;
   logic [REG_AW-1:0] field_addr [3];

   // rs, rt, rd sit at bits 25:21, 20:16, 15:11 of the instruction word.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_field
         assign field_addr[gi] = REG_AW'(ir_reg[21 - 5*gi +: 5]);
      end
   endgenerate

   always_comb begin
      opcode     = ir_reg[31:26];
      funct      = ir_reg[5:0];
      is_rtype   = (opcode == OP_RTYPE);
      is_addi    = (opcode == OP_ADDI);
      is_lw      = (opcode == OP_LW);
      is_sw      = (opcode == OP_SW);
      is_beq     = (opcode == OP_BEQ);
      is_j       = (opcode == OP_J);
      funct_ok   = 1'b1;
      dec_alu_op = 4'b0001;
      if (is_rtype) begin
         case (funct)
            6'h20:   dec_alu_op = 4'b0001;
            6'h22:   dec_alu_op = 4'b0101;
            6'h24:   dec_alu_op = 4'b0000;
            6'h25:   dec_alu_op = 4'b0010;
            6'h27:   dec_alu_op = 4'b1000;
            6'h2A:   dec_alu_op = 4'b0111;
            default: funct_ok   = 1'b0;
         endcase
      end else if (is_beq) begin
         dec_alu_op = 4'b0101;
      end
      illegal  = !((is_rtype && funct_ok) || is_addi || is_lw || is_sw || is_beq || is_j);
      is_arith = is_addi || (is_rtype && (funct == 6'h20 || funct == 6'h22));
   end

`ifdef OVERFLOW_TRAP_EN
   assign ovf_trap = is_arith && alu_ovf;
`else
   logic unused_ovf;
   assign unused_ovf = is_arith & alu_ovf;
   assign ovf_trap   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_FETCH;
         ir_reg       <= '0;
         pc_reg       <= '0;
         imem_req_reg <= 1'b0;
         dmem_req_reg <= 1'b0;
         dmem_we_reg  <= 1'b0;
         reg_we_reg   <= 1'b0;
         wb_sel_reg   <= 1'b0;
         alu_src_reg  <= 1'b0;
         alu_op_reg   <= 4'b0000;
         halted_reg   <= 1'b0;
      end else begin
         case (state_reg)
            S_FETCH: begin
               // req is raised one cycle before ack can be honoured, so ack never feeds req.
               if (imem_req_reg && mem.imem_ack) begin
                  imem_req_reg <= 1'b0;
                  ir_reg       <= mem.imem_data;
                  pc_reg       <= pc_reg + ADDR_W'(1);
                  state_reg    <= S_DECODE;
               end else begin
                  imem_req_reg <= 1'b1;
               end
            end
            S_DECODE: begin
               if (illegal) begin
                  halted_reg <= 1'b1;
                  state_reg  <= S_TRAP;
               end else if (is_j) begin
                  pc_reg       <= ADDR_W'(ir_reg[15:0]);
                  imem_req_reg <= 1'b1;
                  state_reg    <= S_FETCH;
               end else begin
                  alu_op_reg  <= dec_alu_op;
                  alu_src_reg <= is_addi || is_lw || is_sw;
                  state_reg   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (ovf_trap) begin
                  halted_reg <= 1'b1;
                  state_reg  <= S_TRAP;
               end else if (is_beq) begin
                  if (alu_zero) begin
                     pc_reg <= pc_reg + imm_ext[ADDR_W-1:0];
                  end
                  imem_req_reg <= 1'b1;
                  state_reg    <= S_FETCH;
               end else if (is_lw || is_sw) begin
                  dmem_req_reg <= 1'b1;
                  dmem_we_reg  <= is_sw;
                  state_reg    <= S_MEM;
               end else begin
                  reg_we_reg <= 1'b1;
                  wb_sel_reg <= 1'b0;
                  state_reg  <= S_WB;
               end
            end
            S_MEM: begin
               if (mem.dmem_ack) begin
                  dmem_req_reg <= 1'b0;
                  dmem_we_reg  <= 1'b0;
                  if (is_lw) begin
                     reg_we_reg <= 1'b1;
                     wb_sel_reg <= 1'b1;
                     state_reg  <= S_WB;
                  end else begin
                     imem_req_reg <= 1'b1;
                     state_reg    <= S_FETCH;
                  end
               end
            end
            S_WB: begin
               reg_we_reg   <= 1'b0;
               wb_sel_reg   <= 1'b0;
               imem_req_reg <= 1'b1;
               state_reg    <= S_FETCH;
            end
            S_TRAP: begin
               imem_req_reg <= 1'b0;
               dmem_req_reg <= 1'b0;
               dmem_we_reg  <= 1'b0;
               reg_we_reg   <= 1'b0;
               halted_reg   <= 1'b1;
            end
            default: begin
               halted_reg <= 1'b1;
               state_reg  <= S_TRAP;
            end
         endcase
      end
   end

   // rd_addr carries the write destination: rd for R-type, rt for addi/lw.
   assign rs_addr       = field_addr[0];
   assign rt_addr       = field_addr[1];
   assign rd_addr       = is_rtype ? field_addr[2] : field_addr[1];
   assign imm_ext       = DATA_W'($signed(ir_reg[15:0]));
   assign pc            = pc_reg;
   assign mem.imem_addr = pc_reg;
   assign mem.imem_req  = imem_req_reg;
   assign mem.dmem_req  = dmem_req_reg;
   assign mem.dmem_we   = dmem_we_reg;
   assign reg_we        = reg_we_reg;
   assign wb_sel        = wb_sel_reg;
   assign alu_op        = alu_op_reg;
   assign alu_src       = alu_src_reg;
   assign halted        = halted_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised bench for multicycle_ctrl: instruction-level reference model, wait-stated memories.
module tb_multicycle_ctrl;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int REG_AW = 5;
`ifdef OVERFLOW_TRAP_EN
   localparam bit OVF_TRAP = 1'b1;
`else
   localparam bit OVF_TRAP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [REG_AW-1:0] rs_addr, rt_addr, rd_addr;
   logic              reg_we, wb_sel, alu_src, alu_zero, alu_ovf, halted;
   logic [3:0]        alu_op;
   logic [DATA_W-1:0] imm_ext;
   logic [ADDR_W-1:0] pc;
   int                errors = 0;
   int                checks = 0;
   logic [15:0]       model_pc;
   logic              trapped;

   multicycle_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   multicycle_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst_n(rst_n), .mem(bus),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .reg_we(reg_we), .wb_sel(wb_sel), .alu_op(alu_op), .alu_src(alu_src),
      .imm_ext(imm_ext), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
      .pc(pc), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        trap;
      int          lat;
      int          trap_after;
      logic [15:0] next_pc;
      logic [3:0]  op;
      logic        src;
      logic        exec;
      logic        mem;
      logic        store;
      logic        we;
      logic [4:0]  dest;
      logic        wbsel;
   } exp_t;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (pc model 0x%0h)", tag, got, want, model_pc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Instruction-level behaviour: what the core should do with one instruction at cur_pc.
   function automatic exp_t model(input logic [31:0] ins, input logic zero, input logic ovf,
                                  input logic [15:0] cur_pc);
      exp_t        e;
      logic [15:0] pc_inc;
      logic        arith;
      e         = '{default: '0};
      pc_inc    = cur_pc + 16'd1;
      e.next_pc = pc_inc;
      e.exec    = 1'b1;
      arith     = 1'b0;
      case (ins[31:26])
         6'h00: begin
            e.we = 1'b1; e.dest = ins[15:11]; e.lat = 4;
            case (ins[5:0])
               6'h20:   begin e.op = 4'b0001; arith = 1'b1; end
               6'h22:   begin e.op = 4'b0101; arith = 1'b1; end
               6'h24:   e.op = 4'b0000;
               6'h25:   e.op = 4'b0010;
               6'h27:   e.op = 4'b1000;
               6'h2A:   e.op = 4'b0111;
               default: e.trap = 1'b1;
            endcase
         end
         6'h08: begin e.op = 4'b0001; e.src = 1'b1; e.we = 1'b1; e.dest = ins[20:16]; e.lat = 4; arith = 1'b1; end
         6'h23: begin e.op = 4'b0001; e.src = 1'b1; e.mem = 1'b1; e.we = 1'b1; e.dest = ins[20:16];
                      e.wbsel = 1'b1; e.lat = 5; end
         6'h2B: begin e.op = 4'b0001; e.src = 1'b1; e.mem = 1'b1; e.store = 1'b1; e.lat = 4; end
         6'h04: begin e.op = 4'b0101; e.lat = 3; if (zero) e.next_pc = pc_inc + ins[15:0]; end
         6'h02: begin e.exec = 1'b0; e.lat = 2; e.next_pc = ins[15:0]; end
         default: e.trap = 1'b1;
      endcase
      if (e.trap) begin
         e.trap_after = 2; e.exec = 1'b0; e.we = 1'b0; e.mem = 1'b0; e.next_pc = pc_inc;
      end else if (arith && ovf && OVF_TRAP) begin
         e.trap = 1'b1; e.trap_after = 3; e.we = 1'b0; e.next_pc = pc_inc;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0]  opcs   [6] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
      logic [5:0]  functs [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
      logic [31:0] r;
      r        = $urandom;
      r[31:26] = opcs[$urandom_range(0, 5)];
      if (r[31:26] == 6'h00) r[5:0] = functs[$urandom_range(0, 5)];
      return r;
   endfunction

   // Entered at a sample where imem_req should be high for the fetch at model_pc.
   task automatic run_instr(input logic [31:0] ins, input int iwait, input int dwait,
                            input logic zero, input logic ovf);
      exp_t e;
      int   after, dcnt, we_cnt;
      bit   done;
      e = model(ins, zero, ovf, model_pc);
      alu_zero = zero;
      alu_ovf  = ovf;
      check_eq("fetch_addr", bus.imem_addr, model_pc);
      for (int w = 0; w < iwait; w++) begin
         check_eq("ireq_hold", bus.imem_req, 1);
         bus.imem_ack  = 1'b0;
         bus.imem_data = $urandom;
         step();
      end
      check_eq("ireq_hold", bus.imem_req, 1);
      bus.imem_ack  = 1'b1;
      bus.imem_data = ins;
      step();
      after = 1; dcnt = 0; we_cnt = 0; done = 1'b0;
      while (!done && after <= 30) begin
         if (bus.imem_req) begin
            done = 1'b1;
            check_eq("halted", halted, e.trap);
            check_eq("latency", after, e.lat + (e.mem ? dwait : 0));
            check_eq("next_pc", bus.imem_addr, e.next_pc);
            check_eq("reg_we_cnt", we_cnt, e.we);
            check_eq("dmem_cnt", dcnt, e.mem ? dwait + 1 : 0);
         end else if (halted) begin
            done = 1'b1;
            check_eq("halted", halted, e.trap);
            check_eq("trap_lat", after, e.trap_after);
            check_eq("trap_pc", pc, e.next_pc);
            check_eq("trap_we", we_cnt, 0);
         end else begin
            if (after == 1) begin
               check_eq("rs_addr", rs_addr, ins[25:21]);
               check_eq("rt_addr", rt_addr, ins[20:16]);
            end
            if (after == 2 && e.exec) begin
               check_eq("alu_op", alu_op, e.op);
               check_eq("alu_src", alu_src, e.src);
               check_eq("imm_ext", imm_ext, ins[15:0]);
            end
            if (bus.dmem_req) begin
               dcnt++;
               check_eq("dmem_we", bus.dmem_we, e.store);
               bus.dmem_ack = (dcnt > dwait);
            end else begin
               bus.dmem_ack = 1'($urandom_range(0, 1));
            end
            if (reg_we) begin
               we_cnt++;
               check_eq("wb_dest", rd_addr, e.dest);
               check_eq("wb_sel", wb_sel, e.wbsel);
            end
            bus.imem_ack  = 1'($urandom_range(0, 1));
            bus.imem_data = $urandom;
            step();
            after++;
         end
      end
      check_eq("instr_done", done, 1);
      model_pc = e.next_pc;
      trapped  = e.trap | halted;
      $display("instr %08h: pc_next=%04h trap=%0d cycles=%0d", ins, model_pc, trapped, after);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      #1;
      check_eq("rst_ctrl", {bus.imem_req, bus.dmem_req, bus.dmem_we, reg_we, wb_sel, alu_src, halted}, 0);
      check_eq("rst_pc", pc, 0);
      check_eq("rst_alu_op", alu_op, 0);
      check_eq("rst_imm", imm_ext, 0);
      check_eq("rst_addr", {rs_addr, rt_addr, rd_addr}, 0);
      step();
      step();
      rst_n = 1'b1;
      step();
      check_eq("first_fetch", bus.imem_req, 1);
      check_eq("first_addr", bus.imem_addr, 0);
      model_pc = 16'd0;
      trapped  = 1'b0;
      $display("reset: fetch restarts at 0");
   endtask

   task automatic halt_hold();
      for (int k = 0; k < 20; k++) begin
         bus.imem_ack  = 1'($urandom_range(0, 1));
         bus.dmem_ack  = 1'($urandom_range(0, 1));
         bus.imem_data = $urandom;
         step();
         check_eq("trap_hold", {halted, bus.imem_req, bus.dmem_req, bus.dmem_we, reg_we}, 5'b10000);
      end
      $display("trap held for 20 cycles");
   endtask

   task automatic exec_instr(input logic [31:0] ins, input int iwait, input int dwait,
                             input logic zero, input logic ovf);
      run_instr(ins, iwait, dwait, zero, ovf);
      if (trapped) begin
         halt_hold();
         do_reset();
      end
   endtask

   // Abandon a store mid-handshake with an asynchronous reset.
   task automatic reset_during_sw();
      check_eq("fetch_addr", bus.imem_addr, model_pc);
      bus.dmem_ack  = 1'b0;
      bus.imem_ack  = 1'b1;
      bus.imem_data = {6'h2B, 5'd2, 5'd6, 16'h0010};
      step();
      bus.imem_ack = 1'b0;
      for (int k = 0; k < 10 && !bus.dmem_req; k++) step();
      check_eq("sw_dreq_up", bus.dmem_req, 1);
      check_eq("sw_dwe_up", bus.dmem_we, 1);
      step();
      $display("sw pending, asserting reset");
      do_reset();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.imem_ack  = 1'b0;
      bus.imem_data = '0;
      bus.dmem_ack  = 1'b0;
      alu_zero = 1'b0;
      alu_ovf  = 1'b0;
      trapped  = 1'b0;
      model_pc = 16'd0;
      #2;
      do_reset();
      exec_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 0, 0, 1'b0, 1'b0);
      exec_instr({6'h23, 5'd4, 5'd7, 16'hFFFC}, 2, 3, 1'b0, 1'b0);
      exec_instr({6'h02, 10'd0, 16'h0005}, 0, 0, 1'b0, 1'b0);
      exec_instr({6'h04, 5'd1, 5'd1, 16'hFFFE}, 0, 0, 1'b1, 1'b0);
      exec_instr({6'h02, 10'd0, 16'h0005}, 1, 0, 1'b0, 1'b0);
      exec_instr({6'h04, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b0, 1'b0);
      exec_instr({6'h02, 10'd0, 16'h0100}, 0, 0, 1'b0, 1'b0);
      exec_instr({6'h02, 10'd0, 16'hFFFF}, 0, 0, 1'b0, 1'b0);
      exec_instr({6'h08, 5'd3, 5'd9, 16'h8000}, 0, 0, 1'b0, 1'b0);
      exec_instr({6'h2B, 5'd5, 5'd0, 16'h0004}, 1, 2, 1'b0, 1'b0);
      for (int n = 0; n < 120; n++) begin
         exec_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      end
      exec_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 0, 0, 1'b0, 1'b1);
      exec_instr({6'h08, 5'd1, 5'd4, 16'h7FFF}, 1, 0, 1'b0, 1'b1);
      exec_instr({6'h3F, 26'h0123456}, 0, 0, 1'b0, 1'b0);
      exec_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h01}, 2, 0, 1'b0, 1'b0);
      reset_during_sw();
      exec_instr({6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h2A}, 0, 0, 1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
